dmem_arbiter: RTL

Two-port arbiter and sequencer in front of the single-port 64-bit data memory. It shares the memory between the core load/store unit (requester 0) and the debug/loader port (requester 1). Each access runs as an explicit three-state transaction, and illegal accesses are caught before they reach the memory. It sits between the execute/memory stage and the data memory instance.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_access_check.sv | 41 ++++
 rtl/dmem_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory arbiter:
//               transaction state encoding, access error causes, data width.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Width of one memory word and of all data buses around the memory
    localparam int unsigned c_data_w = 64;

    // Arbiter transaction sequencing: accept -> memory access -> response
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmem_arb_state_t;

    // Reason an access was refused; NONE means it may reach the memory
    typedef enum logic [1:0] {
        NONE     = 2'd0,
        MISALIGN = 2'd1,
        RANGE    = 2'd2,
        ROM_WR   = 2'd3
    } dmem_err_t;

endpackage
`default_nettype wire

// File: rtl/dmem_access_check.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_check
// Description : Combinational legality check of a latched memory request.
//               Misalignment is reported first, then out-of-range, then a
//               write into the read-only region at the bottom of memory.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_check
    import dmem_pkg::*;
#(
    parameter int unsigned mem_size = 256,
    parameter int unsigned rom_size = 8,
    parameter int unsigned addr_w   = 32
) (
    input  logic              we_i,
    input  logic [addr_w-1:0] addr_i,
    output dmem_err_t         err_o
);

    localparam logic [addr_w-1:0] c_mem_words = addr_w'(mem_size);
    localparam logic [addr_w-1:0] c_rom_words = addr_w'(rom_size);

    // Word index of the byte address (memory words are 8 bytes wide)
    logic [addr_w-1:0] w_word;
    assign w_word = addr_i >> 3;

    // Classify the access; the first matching rule gives the cause
    always_comb begin
        err_o = NONE;
        if (addr_i[2:0] != 3'b000) begin
            err_o = MISALIGN;
        end else if (w_word >= c_mem_words) begin
            err_o = RANGE;
        end else if (we_i && (w_word < c_rom_words)) begin
            err_o = ROM_WR;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-requester arbiter and sequencer in front of the
//               single-port 64-bit data memory. Requester 0 is the core
//               load/store unit, requester 1 the debug/loader port. Every
//               access is a three-cycle transaction (accept, access,
//               respond); illegal accesses never reach the memory.
// Config      : DMEM_ARB_RR_EN - defined: round-robin on ties;
//               undefined: fixed priority, requester 0 always wins ties.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned mem_size = 256,
    parameter int unsigned rom_size = 8,
    parameter int unsigned addr_w   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [1:0]                  req_we,
    input  logic [1:0][addr_w-1:0]      req_addr,
    input  logic [1:0][c_data_w-1:0]    req_wdata,
    output logic [1:0]                  rsp_valid,
    output logic                        rsp_err,
    output logic [c_data_w-1:0]         rsp_rdata,
    output logic [addr_w-1:0]           mem_addr,
    output logic [c_data_w-1:0]         mem_wr_data,
    output logic                        mem_wr_enable,
    output logic                        mem_rd_enable,
    input  logic [c_data_w-1:0]         mem_rd_data
);

    dmem_arb_state_t       state_q;
    dmem_arb_state_t       state_d;

    // Latched transaction
    logic                  winner_q;
    logic                  we_q;
    logic [addr_w-1:0]     addr_q;
    logic [c_data_w-1:0]   wdata_q;

    // Response register, filled during the access cycle
    logic                  err_q;
    logic [c_data_w-1:0]   rdata_q;

    logic                  w_any_req;
    logic                  w_grant;
    logic                  w_legal;
    dmem_err_t             w_err_cause;

`ifdef DMEM_ARB_RR_EN
    logic                  last_grant_q;
`endif

    assign w_any_req = |req_valid;

    // Pick the requester to serve when both are asking
    always_comb begin
        w_grant = 1'b0;
        if (req_valid == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
            w_grant = ~last_grant_q;
`else
            w_grant = 1'b0;
`endif
        end else if (req_valid[1]) begin
            w_grant = 1'b1;
        end
    end

    dmem_access_check #(
        .mem_size (mem_size),
        .rom_size (rom_size),
        .addr_w   (addr_w)
    ) u_access_check (
        .we_i     (we_q),
        .addr_i   (addr_q),
        .err_o    (w_err_cause)
    );

    assign w_legal = (w_err_cause == NONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one access every three cycles, IDLE waits for a request
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_any_req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: accept pulse, memory strobes and response pulse; all held low
    // while reset is asserted so an in-flight write cannot land in memory
    always_comb begin
        req_ready     = '0;
        rsp_valid     = '0;
        rsp_err       = 1'b0;
        rsp_rdata     = '0;
        mem_addr      = '0;
        mem_wr_data   = '0;
        mem_wr_enable = 1'b0;
        mem_rd_enable = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (w_any_req) req_ready[w_grant] = 1'b1;
                end
                ACCESS: begin
                    if (w_legal) begin
                        mem_addr      = addr_q;
                        mem_wr_enable = we_q;
                        mem_rd_enable = ~we_q;
                        if (we_q) mem_wr_data = wdata_q;
                    end
                end
                RESP: begin
                    rsp_valid[winner_q] = 1'b1;
                    rsp_err             = err_q;
                    rsp_rdata           = rdata_q;
                end
                default: ;
            endcase
        end
    end

    // Latch the accepted request, then capture the access result
    always_ff @(posedge clk) begin
        if (rst) begin
            winner_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_any_req) begin
                        winner_q <= w_grant;
                        we_q     <= req_we[w_grant];
                        addr_q   <= req_addr[w_grant];
                        wdata_q  <= req_wdata[w_grant];
                    end
                end
                ACCESS: begin
                    err_q   <= ~w_legal;
                    rdata_q <= (w_legal && !we_q) ? mem_rd_data : '0;
                end
                default: ;
            endcase
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Remember who was served last so the next tie goes to the other side;
    // reset value 1 lets requester 0 win the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else if (state_q == RESP) begin
            last_grant_q <= winner_q;
        end
    end
`endif

endmodule
`default_nettype wire
